// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the memory-stage result, folds in data-TLB faults,
// and raises fetch_wait from the first faulting entry until the handler acknowledges it.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              in_exception,
    input  logic [ADDR_W-1:0] in_faulty_address,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_enable,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              dtlb_miss,
    input  logic              dtlb_ready,
    input  logic              exc_ack,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_exception,
    output logic [ADDR_W-1:0] out_faulty_address,
    output logic              fetch_wait
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } fw_state_t;

    fw_state_t         state;
    fw_state_t         state_next;

    logic              dtlb_fault;
    logic              load;
    logic              load_exc;
    logic [DATA_W-1:0] wb_sel;
    logic [ADDR_W-1:0] fa_sel;

    logic              valid_q;
    logic [REG_AW-1:0] rd_q;
    logic              reg_write_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] pc_q;
    logic              exc_q;
    logic [ADDR_W-1:0] fa_q;

    // Write-back mux sits ahead of the flop so out_wb_data comes straight from a register.
    always_comb begin
        dtlb_fault = in_valid & mem_enable & dtlb_miss & dtlb_ready;
        load       = ~flush & ~stall;
        load_exc   = load & in_valid & (in_exception | dtlb_fault);
        wb_sel     = in_mem_to_reg ? mem_read_data : in_result;
        fa_sel     = '0;
        if (in_exception) begin
            fa_sel = in_faulty_address;
        end else if (dtlb_fault) begin
            fa_sel = mem_address;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_data_q   <= '0;
            pc_q        <= '0;
            exc_q       <= 1'b0;
            fa_q        <= '0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
            wb_data_q   <= wb_sel;
            pc_q        <= in_pc;
            exc_q       <= in_valid & (in_exception | dtlb_fault);
            fa_q        <= fa_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A freshly loaded exception keeps fetch stopped even if the old one is acknowledged.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (load_exc) state_next = ST_WAIT;
            ST_WAIT: if (exc_ack && !load_exc) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        fetch_wait         = (state == ST_WAIT);
        out_valid          = valid_q;
        out_rd             = rd_q;
        out_reg_write      = reg_write_q & valid_q & ~exc_q;
        out_wb_data        = wb_data_q;
        out_pc             = pc_q;
        out_exception      = exc_q;
        out_faulty_address = fa_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; expected values are hand-computed constants.
module tb_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic [31:0] in_pc;
    logic        in_exception;
    logic [31:0] in_faulty_address;
    logic [31:0] mem_read_data;
    logic        mem_enable;
    logic [31:0] mem_address;
    logic        dtlb_miss;
    logic        dtlb_ready;
    logic        exc_ack;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] out_wb_data;
    logic [31:0] out_pc;
    logic        out_exception;
    logic [31:0] out_faulty_address;
    logic        fetch_wait;

    int tests_run    = 0;
    int tests_failed = 0;

    // Packed view of every output: valid, rd, reg_write, wb_data, pc, exception, faulty_address, fetch_wait.
    logic [104:0] snap;
    assign snap = {out_valid, out_rd, out_reg_write, out_wb_data, out_pc,
                   out_exception, out_faulty_address, fetch_wait};

    always #5 clock = ~clock;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_result(in_result), .in_rd(in_rd),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_pc(in_pc),
        .in_exception(in_exception), .in_faulty_address(in_faulty_address),
        .mem_read_data(mem_read_data), .mem_enable(mem_enable), .mem_address(mem_address),
        .dtlb_miss(dtlb_miss), .dtlb_ready(dtlb_ready), .exc_ack(exc_ack),
        .out_valid(out_valid), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_wb_data(out_wb_data), .out_pc(out_pc), .out_exception(out_exception),
        .out_faulty_address(out_faulty_address), .fetch_wait(fetch_wait)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; stall = 0; flush = 0; in_valid = 0; in_result = 0; in_rd = 0;
        in_mem_to_reg = 0; in_reg_write = 0; in_pc = 0; in_exception = 0;
        in_faulty_address = 0; mem_read_data = 0; mem_enable = 0; mem_address = 0;
        dtlb_miss = 0; dtlb_ready = 0; exc_ack = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1; in_valid = 1; in_result = 32'h77; in_reg_write = 1;
        tick();
        tick();
        tests_run++;
        if (snap !== 105'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", snap);
        end
        reset = 0; in_valid = 0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid_idle: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_alu_writeback();
        drive_idle();
        in_valid = 1; in_result = 32'h11; in_rd = 5'd3; in_reg_write = 1; in_pc = 32'h100;
        tick();
        tests_run++;
        if ({out_valid, out_wb_data, out_rd, out_reg_write, out_pc, out_exception, fetch_wait}
            !== {1'b1, 32'h11, 5'd3, 1'b1, 32'h100, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL alu_wb: got v=%b d=%h rd=%0d we=%b pc=%h exc=%b fw=%b expected 1 11 3 1 100 0 0",
                     out_valid, out_wb_data, out_rd, out_reg_write, out_pc, out_exception, fetch_wait);
        end
    endtask

    task automatic test_load_data();
        drive_idle();
        in_valid = 1; in_mem_to_reg = 1; mem_read_data = 32'hDEADBEEF; in_result = 32'h40;
        in_rd = 5'd9; in_reg_write = 1;
        tick();
        tests_run++;
        if (out_wb_data !== 32'hDEADBEEF || out_reg_write !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_wb: got d=%h we=%b expected deadbeef 1", out_wb_data, out_reg_write);
        end
        // Valid entry with reg_write=0 must not write.
        in_reg_write = 0;
        tick();
        tests_run++;
        if (out_reg_write !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_write: got %b expected 0", out_reg_write);
        end
    endtask

    task automatic test_dtlb_fault();
        drive_idle();
        in_valid = 1; in_reg_write = 1; mem_enable = 1; dtlb_miss = 1; dtlb_ready = 0;
        mem_address = 32'h1000;
        tick();
        tests_run++;
        if (out_exception !== 1'b0 || fetch_wait !== 1'b0 || out_reg_write !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dtlb_not_ready: got exc=%b fw=%b we=%b expected 0 0 1",
                     out_exception, fetch_wait, out_reg_write);
        end
        dtlb_ready = 1;
        tick();
        tests_run++;
        if ({out_exception, out_faulty_address, out_reg_write, fetch_wait}
            !== {1'b1, 32'h1000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL dtlb_fault: got exc=%b fa=%h we=%b fw=%b expected 1 1000 0 1",
                     out_exception, out_faulty_address, out_reg_write, fetch_wait);
        end
        drive_idle();
        in_valid = 1; in_reg_write = 1;
        tick();
        tests_run++;
        if (fetch_wait !== 1'b1 || out_exception !== 1'b0 || out_faulty_address !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL dtlb_wait_hold: got fw=%b exc=%b fa=%h expected 1 0 0",
                     fetch_wait, out_exception, out_faulty_address);
        end
        exc_ack = 1;
        tick();
        tests_run++;
        if (fetch_wait !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL dtlb_ack: got fw=%b expected 0", fetch_wait);
        end
        // Acknowledge in RUN is a no-op.
        exc_ack = 1;
        tick();
        tests_run++;
        if (fetch_wait !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ack_in_run: got fw=%b expected 0", fetch_wait);
        end
    endtask

    task automatic test_exception_priority();
        drive_idle();
        in_valid = 1; in_reg_write = 1; in_exception = 1; in_faulty_address = 32'h2000;
        mem_enable = 1; dtlb_miss = 1; dtlb_ready = 1; mem_address = 32'h1000;
        tick();
        tests_run++;
        if ({out_exception, out_faulty_address, out_reg_write, fetch_wait}
            !== {1'b1, 32'h2000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL exc_priority: got exc=%b fa=%h we=%b fw=%b expected 1 2000 0 1",
                     out_exception, out_faulty_address, out_reg_write, fetch_wait);
        end
        mem_enable = 0; in_faulty_address = 32'h3000; exc_ack = 1;
        tick();
        tests_run++;
        if (fetch_wait !== 1'b1 || out_faulty_address !== 32'h3000) begin
            tests_failed++;
            $display("[TB] FAIL ack_with_new_exc: got fw=%b fa=%h expected 1 3000", fetch_wait, out_faulty_address);
        end
        drive_idle();
        exc_ack = 1;
        tick();
        tests_run++;
        if (fetch_wait !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ack_release: got fw=%b expected 0", fetch_wait);
        end
    endtask

    task automatic test_invalid_entry();
        drive_idle();
        in_valid = 0; in_exception = 1; in_reg_write = 1; mem_enable = 1; dtlb_miss = 1; dtlb_ready = 1;
        tick();
        tests_run++;
        if ({out_valid, out_exception, out_reg_write, fetch_wait} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL invalid_entry: got v=%b exc=%b we=%b fw=%b expected 0 0 0 0",
                     out_valid, out_exception, out_reg_write, fetch_wait);
        end
    endtask

    task automatic test_stall_flush();
        logic [104:0] held;
        drive_idle();
        in_valid = 1; in_result = 32'h55; in_rd = 5'd7; in_reg_write = 1; in_pc = 32'h200;
        tick();
        held = {1'b1, 5'd7, 1'b1, 32'h55, 32'h200, 1'b0, 32'h0, 1'b0};
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_result = 32'h90 + i; in_rd = 5'(i + 10); in_pc = 32'h300 + i;
            in_exception = 1; in_faulty_address = 32'h4000;
            mem_enable = 1; dtlb_miss = 1; dtlb_ready = 1; mem_address = 32'h5000;
            tick();
            tests_run++;
            if (snap !== held) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, snap, held);
            end
        end
        flush = 1;
        tick();
        tests_run++;
        if (snap !== 105'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_stall_bubble: got %h expected 0", snap);
        end
        // Enter WAIT, then flush must clear the entry but keep fetch stopped.
        drive_idle();
        in_valid = 1; in_exception = 1; in_faulty_address = 32'h6000;
        tick();
        flush = 1;
        tick();
        tests_run++;
        if ({out_valid, out_exception, out_faulty_address, fetch_wait} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL flush_keeps_wait: got v=%b exc=%b fa=%h fw=%b expected 0 0 0 1",
                     out_valid, out_exception, out_faulty_address, fetch_wait);
        end
    endtask

    task automatic test_reset_priority();
        drive_idle();
        reset = 1; stall = 1; in_valid = 1; in_exception = 1; in_result = 32'h99;
        tick();
        tests_run++;
        if (snap !== 105'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_over_wait: got %h expected 0", snap);
        end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        in_valid = 1; in_result = 32'hA1; in_rd = 5'd1; in_reg_write = 1; in_pc = 32'h10;
        tick();
        in_mem_to_reg = 1; mem_read_data = 32'hB2; in_rd = 5'd31; in_pc = 32'h14;
        tests_run++;
        if ({out_wb_data, out_rd, out_pc} !== {32'hA1, 5'd1, 32'h10}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got d=%h rd=%0d pc=%h expected a1 1 10", out_wb_data, out_rd, out_pc);
        end
        tick();
        tests_run++;
        if ({out_wb_data, out_rd, out_pc, out_reg_write} !== {32'hB2, 5'd31, 32'h14, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got d=%h rd=%0d pc=%h we=%b expected b2 31 14 1",
                     out_wb_data, out_rd, out_pc, out_reg_write);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_alu_writeback();
        test_load_data();
        test_dtlb_fault();
        test_exception_priority();
        test_invalid_entry();
        test_stall_flush();
        test_reset_priority();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of result, load data and write-back data.
REQ-002 SHALL have parameter ADDR_W, default 32: width of pc, mem_address and faulty address.
REQ-003 SHALL have parameter REG_AW, default 5: width of destination-register index.
REQ-004 SHALL have ports as follows (one clock; reset synchronous, active-high):
 clock  in  1  sole clock; all state updates on rising edge
 reset  in  1  synchronous, active-high reset
 stall  in  1  hold all stage contents
 flush  in  1  replace stage contents with a bubble
 in_valid  in  1  upstream (EX/MEM) entry valid
 in_result  in  DATA_W  ALU result
 in_rd  in  REG_AW  destination register
 in_mem_to_reg  in  1  select load data for write-back
 in_reg_write  in  1  write-back enable
 in_pc  in  ADDR_W  instruction pc
 in_exception  in  1  upstream exception
 in_faulty_address  in  ADDR_W  upstream faulty address
 mem_read_data  in  DATA_W  data-cache read data
 mem_enable  in  1  data-cache access this cycle
 mem_address  in  ADDR_W  data-cache access address
 dtlb_miss  in  1  data-TLB miss
 dtlb_ready  in  1  data-TLB lookup complete
 exc_ack  in  1  exception handler acknowledge
 out_valid  out  1  stage entry valid
 out_rd  out  REG_AW  destination register
 out_reg_write  out  1  qualified register-file write enable
 out_wb_data  out  DATA_W  write-back data
 out_pc  out  ADDR_W  entry pc
 out_exception  out  1  entry carries exception
 out_faulty_address  out  ADDR_W  faulty address of entry
 fetch_wait  out  1  registered request for fetch to stop issuing

Function
REQ-005 Update priority each rising edge SHALL be: reset > flush > stall > load.
REQ-006 Load SHALL capture all in_* fields, plus mem_read_data, in one cycle; outputs reflect inputs of the previous edge (latency 1).
REQ-007 dtlb_fault SHALL be defined as in_valid & mem_enable & dtlb_miss & dtlb_ready.
REQ-008 On load, out_exception SHALL be in_valid & (in_exception | dtlb_fault).
REQ-009 On load, out_faulty_address SHALL be in_faulty_address if in_exception, else mem_address if dtlb_fault, else 0; upstream exception wins when both present.
REQ-010 out_wb_data SHALL be the captured load data when captured mem_to_reg=1, else the captured result (mux registered, not after the flop).
REQ-011 out_reg_write SHALL be captured reg_write & out_valid & ~out_exception; a faulting entry never writes the register file.
REQ-012 Flush SHALL set out_valid=0, out_reg_write=0, out_exception=0, out_faulty_address=0, out_pc=0; out_rd and out_wb_data cleared to 0.
REQ-013 Stall SHALL hold every output, including out_exception, unchanged; a dtlb_fault presented during stall SHALL NOT be captured.
REQ-014 fetch_wait SHALL be a two-state machine RUN (0) / WAIT (1).
REQ-015 RUN->WAIT on any edge where the stage loads an entry with out_exception=1 (REQ-008).
REQ-016 WAIT->RUN on exc_ack=1 unless the same edge loads a new exception, in which case it stays WAIT.
REQ-017 flush and stall SHALL NOT change fetch_wait; only exc_ack or reset leave WAIT.
REQ-018 exc_ack in RUN SHALL have no effect.
REQ-019 Parameter changes SHALL need no RTL edits; no truncation or extension anywhere in the datapath.

Reset
REQ-020 reset=1 at an edge SHALL set all outputs to 0 and fetch_wait to RUN, regardless of stall, flush, exc_ack or an in-flight exception.
REQ-021 After reset, out_valid=0 until the first load edge with in_valid=1.

Verification
REQ-022 Load in_valid=1, in_result=0x11, in_rd=3, in_reg_write=1, in_mem_to_reg=0 -> next cycle out_wb_data=0x11, out_rd=3, out_reg_write=1, fetch_wait=0.
REQ-023 in_mem_to_reg=1, mem_read_data=0xDEADBEEF, in_result=0x40 -> out_wb_data=0xDEADBEEF.
REQ-024 mem_enable=1, dtlb_miss=1, dtlb_ready=1, mem_address=0x1000, in_exception=0 -> out_exception=1, out_faulty_address=0x1000, out_reg_write=0, fetch_wait=1 until exc_ack.
REQ-025 Same cycle in_exception=1, in_faulty_address=0x2000 plus dtlb_fault at 0x1000 -> out_faulty_address=0x2000; then exc_ack together with a new exception keeps fetch_wait=1.
REQ-026 stall=1 for 3 cycles with changing inputs -> outputs constant; then flush=1 and stall=1 together -> bubble (out_valid=0); fetch_wait unchanged.
REQ-027 reset=1 with fetch_wait=1 and stall=1 -> next cycle all outputs 0, fetch_wait=0.
